// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Sequential restoring divider serving the DIV/DIVU
//               instructions. Takes one request at a time over a valid/ready
//               channel and runs DATA_WIDTH iterations. Quotient and
//               remainder are returned over a valid/ready channel and held
//               until the consumer accepts them.
//               Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the
//               iterations and presents the forced result one cycle after
//               acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  op_signed,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [1:0]       c_IDLE     = 2'd0;
    localparam logic [1:0]       c_CALC     = 2'd1;
    localparam logic [1:0]       c_DONE     = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_op_signed;
    logic                  r_dvd_sign;
    logic                  r_dvs_sign;
    logic                  r_zero;
    logic [DATA_WIDTH-1:0] r_raw_dividend;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_dvd;
    logic [DATA_WIDTH-1:0] r_dvs;
    logic [DATA_WIDTH-1:0] r_quotient;
    logic [DATA_WIDTH-1:0] r_remainder;
    logic                  r_div_by_zero;

    logic                  w_dvd_neg;
    logic                  w_dvs_neg;
    logic [DATA_WIDTH-1:0] w_dvd_mag;
    logic [DATA_WIDTH-1:0] w_dvs_mag;
    logic [DATA_WIDTH:0]   w_shifted;
    logic [DATA_WIDTH:0]   w_diff;
    logic                  w_fits;
    logic [DATA_WIDTH-1:0] w_rem_next;
    logic [DATA_WIDTH-1:0] w_quo_next;
    logic [DATA_WIDTH-1:0] w_quo_fix;
    logic [DATA_WIDTH-1:0] w_rem_fix;
    logic                  w_last;

    assign in_ready    = (r_state == c_IDLE);
    assign out_valid   = (r_state == c_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

    // Operand sign extraction and magnitude conversion at acceptance
    always_comb begin
        w_dvd_neg = op_signed & dividend[DATA_WIDTH-1];
        w_dvs_neg = op_signed & divisor[DATA_WIDTH-1];
        w_dvd_mag = w_dvd_neg ? (~dividend + 1'b1) : dividend;
        w_dvs_mag = w_dvs_neg ? (~divisor + 1'b1) : divisor;
    end

    // One restoring iteration plus sign correction of the final step
    always_comb begin
        // The shifted partial remainder is one bit wider than the data so the
        // MSB of the difference is a clean borrow/sign indicator.
        w_shifted  = {r_rem, r_dvd[DATA_WIDTH-1]};
        w_diff     = w_shifted - {1'b0, r_dvs};
        w_fits     = ~w_diff[DATA_WIDTH];
        w_rem_next = w_fits ? w_diff[DATA_WIDTH-1:0] : w_shifted[DATA_WIDTH-1:0];
        w_quo_next = {r_dvd[DATA_WIDTH-2:0], w_fits};
        w_quo_fix  = (r_op_signed & (r_dvd_sign ^ r_dvs_sign)) ?
                     (~w_quo_next + 1'b1) : w_quo_next;
        // Remainder takes the sign of the dividend (truncating division).
        w_rem_fix  = (r_op_signed & r_dvd_sign) ? (~w_rem_next + 1'b1) : w_rem_next;
`ifdef DIV_ZERO_FAST_EN
        w_last     = (r_cnt == '0) | r_zero;
`else
        w_last     = (r_cnt == '0);
`endif
    end

    // Control FSM, datapath registers and held result registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state        <= c_IDLE;
            r_cnt          <= '0;
            r_op_signed    <= 1'b0;
            r_dvd_sign     <= 1'b0;
            r_dvs_sign     <= 1'b0;
            r_zero         <= 1'b0;
            r_raw_dividend <= '0;
            r_rem          <= '0;
            r_dvd          <= '0;
            r_dvs          <= '0;
            r_quotient     <= '0;
            r_remainder    <= '0;
            r_div_by_zero  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_op_signed    <= op_signed;
                        r_dvd_sign     <= w_dvd_neg;
                        r_dvs_sign     <= w_dvs_neg;
                        r_zero         <= (divisor == '0);
                        r_raw_dividend <= dividend;
                        r_dvd          <= w_dvd_mag;
                        r_dvs          <= w_dvs_mag;
                        r_rem          <= '0;
                        r_cnt          <= c_CNT_LAST;
                        r_state        <= c_CALC;
                    end
                end
                c_CALC: begin
                    r_rem <= w_rem_next;
                    r_dvd <= w_quo_next;
                    if (w_last) begin
                        // A zero divisor overrides whatever the iterations produced.
                        r_quotient    <= r_zero ? '1 : w_quo_fix;
                        r_remainder   <= r_zero ? r_raw_dividend : w_rem_fix;
                        r_div_by_zero <= r_zero;
                        r_state       <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Self-checking bench for div_unit. Directed corner cases plus
//               randomized divisions compared against an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic        op_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_checks;
    int n_fail;

    div_unit #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_signed  (op_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: truncating division, remainder follows dividend sign.
    task automatic ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r, output bit dz);
        longint sa, sb;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            dz = 1'b0;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end
    endtask

    // Issue one request, wait for the result, check latency and values.
    // With release=0 the result is left pending in DONE.
    task automatic do_div(input string tag, input bit s, input logic [31:0] a,
                          input logic [31:0] b, input bit release_it);
        logic [31:0] eq, er;
        bit          edz;
        int          lat;
        int          exp_lat;
        ref_div(s, a, b, eq, er, edz);
`ifdef DIV_ZERO_FAST_EN
        exp_lat = (b == 32'd0) ? 1 : 32;
`else
        exp_lat = 32;
`endif
        check({tag, ":in_ready"}, {31'd0, in_ready}, 32'd1);
        op_signed = s;
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 100);
        check({tag, ":latency"}, lat, exp_lat);
        if (!out_valid) return;
        check({tag, ":quotient"}, quotient, eq);
        check({tag, ":remainder"}, remainder, er);
        check({tag, ":div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edz});
        if (release_it) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check({tag, ":out_valid_drop"}, {31'd0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] a, b;
        bit          s;
        n_checks  = 0;
        n_fail    = 0;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst:in_ready", {31'd0, in_ready}, 32'd1);
        check("rst:out_valid", {31'd0, out_valid}, 32'd0);
        check("rst:quotient", quotient, 32'd0);
        check("rst:remainder", remainder, 32'd0);
        check("rst:div_by_zero", {31'd0, div_by_zero}, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b1);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        do_div("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        do_div("divu_zero", 1'b0, 32'h1234_5678, 32'd0, 1'b1);
        do_div("div_zero", 1'b1, 32'h8765_4321, 32'd0, 1'b1);

        // Backpressure: result held while a different request is offered
        do_div("bp", 1'b0, 32'd1000, 32'd33, 1'b0);
        op_signed = 1'b1;
        dividend  = 32'hFFFF_FF00;
        divisor   = 32'd5;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp:hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp:hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp:hold_quotient", quotient, 32'd30);
            check("bp:hold_remainder", remainder, 32'd10);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp:in_ready_after", {31'd0, in_ready}, 32'd1);
        check("bp:out_valid_after", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp:accepted", {31'd0, in_ready}, 32'd0);
        begin
            int lat = 0;
            while (!out_valid && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            check("bp:second_latency", lat, 32);
            check("bp:second_quotient", quotient, 32'hFFFF_FFCD);
            check("bp:second_remainder", remainder, 32'hFFFF_FFFF);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end

        // Reset in the middle of an iteration run
        op_signed = 1'b0;
        dividend  = 32'hDEAD_BEEF;
        divisor   = 32'd3;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        check("mid_rst:in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst:out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst:quotient", quotient, 32'd0);
        check("mid_rst:remainder", remainder, 32'd0);
        check("mid_rst:div_by_zero", {31'd0, div_by_zero}, 32'd0);
        do_div("after_rst", 1'b0, 32'd9, 32'd3, 1'b1);

        // Randomized divisions with corner-value mixing
        for (int n = 0; n < 60; n++) begin
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                2: a = $urandom_range(0, 50);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'd1;
                2: b = 32'hFFFF_FFFF;
                3: b = $urandom_range(1, 15);
                4: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            do_div("rand", s, a, b, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
